// File: rtl/crossfade_sequencer_if.sv
// crossfade_sequencer_if
// Control and output bundle for the crossfade sequencer.
//   ready      sample strobe (one cycle per audio sample)
//   start      one-cycle fade request
//   direction  0 = fade toward track 2, 1 = fade toward track 1
//   rate       step period is (rate+1)*256 ready pulses
//   abort      one-cycle request to stop a fade and freeze the weights
//   freq_bass  lowest-band magnitude, sampled on ready
//   weight1/2  mixer weights, 0..16
//   busy       high while fading
//   done       one-cycle completion pulse
// master: the side driving the controls; slave: the sequencer.
interface crossfade_sequencer_if;
    logic       ready;
    logic       start;
    logic       direction;
    logic [3:0] rate;
    logic       abort;
    logic [7:0] freq_bass;
    logic [4:0] weight1;
    logic [4:0] weight2;
    logic       busy;
    logic       done;

    modport master (
        output ready, start, direction, rate, abort, freq_bass,
        input  weight1, weight2, busy, done
    );

    modport slave (
        input  ready, start, direction, rate, abort, freq_bass,
        output weight1, weight2, busy, done
    );
endinterface

// File: rtl/crossfade_sequencer.sv
// crossfade_sequencer
// Steps a pair of complementary mixer weights (w1, 16-w1) one unit per
// step period toward track 1 or track 2, with abort and a completion pulse.
// Ports:
//   clock  system clock
//   reset  synchronous, active-high
//   bus    crossfade_sequencer_if.slave (controls in, weights/status out)
// Parameters:
//   DUCK_THRESH  bass magnitude at or above which ducking triggers
//   DUCK_HOLD    ready pulses a duck lasts after its last trigger
// Build option:
//   BASS_DUCK_EN  when defined, loud bass halves both output weights for
//                 DUCK_HOLD ready pulses after the last loud sample.
module crossfade_sequencer #(
    parameter logic [7:0] DUCK_THRESH = 8'd192,
    parameter int         DUCK_HOLD   = 2400
) (
    input  logic                  clock,
    input  logic                  reset,
    crossfade_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FADE, DONE} state_t;

    state_t      state;
    logic        dir_q;
    logic [3:0]  rate_q;
    logic [11:0] step_cnt;
    logic [4:0]  w1;
    logic [4:0] w1_next;
    logic        busy_q;
    logic        done_q;
    logic [4:0]  weight1_q;
    logic [4:0]  weight2_q;
    logic        step_fire;
    logic        ducked;
    logic [4:0]  fade_target;
    logic [4:0]  start_target;

    assign fade_target  = dir_q         ? 5'd16 : 5'd0;
    assign start_target = bus.direction ? 5'd16 : 5'd0;

    // A step lands on the ready pulse that ends a period. The bound test
    // keeps w1 inside 0..16 regardless of how the FSM got here.
    always_comb begin
        step_fire = (state == FADE) && !bus.abort && bus.ready &&
                    (step_cnt == {rate_q, 8'hFF}) &&
                    (dir_q ? (w1 < 5'd16) : (w1 > 5'd0));
        w1_next = w1;
        if (step_fire)
            w1_next = dir_q ? w1 + 5'd1 : w1 - 5'd1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            w1 <= 5'd16;
        else
            w1 <= w1_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            step_cnt <= '0;
            dir_q    <= 1'b0;
            rate_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        dir_q    <= bus.direction;
                        rate_q   <= bus.rate;
                        step_cnt <= '0;
                        if (w1 == start_target) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= FADE;
                            busy_q <= 1'b1;
                        end
                    end
                end
                FADE: begin
                    // abort outranks both completion and stepping
                    if (bus.abort) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (w1 == fade_target) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else if (bus.ready) begin
                        step_cnt <= step_fire ? 12'd0 : step_cnt + 12'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef BASS_DUCK_EN
    localparam int DW = $clog2(DUCK_HOLD + 1);

    logic [DW-1:0] duck_cnt;
    logic [DW-1:0] duck_next;

    always_comb begin
        duck_next = duck_cnt;
        if (bus.ready) begin
            if (bus.freq_bass >= DUCK_THRESH)
                duck_next = DW'(DUCK_HOLD);
            else if (duck_cnt != '0)
                duck_next = duck_cnt - DW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            duck_cnt <= '0;
        else
            duck_cnt <= duck_next;
    end

    // Use the next duck count so the halving appears alongside any step
    // from the same ready pulse.
    assign ducked = (duck_next != '0);
`else
    logic unused_duck;
    assign unused_duck = (^{bus.freq_bass, DUCK_THRESH}) ^ (DUCK_HOLD != 0);
    assign ducked      = 1'b0;
`endif

    // Outputs are registered from next-state values so a step is visible
    // the cycle after the ready pulse that caused it.
    always_ff @(posedge clock) begin
        if (reset) begin
            weight1_q <= 5'd16;
            weight2_q <= 5'd0;
        end else if (ducked) begin
            weight1_q <= w1_next >> 1;
            weight2_q <= (5'd16 - w1_next) >> 1;
        end else begin
            weight1_q <= w1_next;
            weight2_q <= 5'd16 - w1_next;
        end
    end

    assign bus.weight1 = weight1_q;
    assign bus.weight2 = weight2_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_crossfade_sequencer.sv
// tb_crossfade_sequencer
// Randomized and directed stimulus for crossfade_sequencer, checked every
// cycle against a fade model that derives w1 from the number of ready
// pulses seen since the fade started.
module tb_crossfade_sequencer;
    logic clock;
    logic reset;
    crossfade_sequencer_if bus();

    crossfade_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec;
    int n_err;
    int n_done;

    // model state
    int m_w1, m_w0, m_pulses, m_period, m_duck;
    bit m_fading, m_dir, m_done;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input bit rst, st, ab, dr, input int rt,
                         input bit rdy, input int bass);
        bit was_done;
        if (rst) begin
            m_w1 = 16; m_fading = 0; m_done = 0; m_duck = 0;
            return;
        end
        was_done = m_done;
        m_done   = 0;
        if (rdy)
            m_duck = (bass >= 192) ? 2400 : (m_duck > 0 ? m_duck - 1 : 0);
        if (m_fading) begin
            if (ab) begin
                m_fading = 0;
            end else if (m_w1 == (m_dir ? 16 : 0)) begin
                m_fading = 0;
                m_done   = 1;
            end else if (rdy) begin
                m_pulses++;
                if (m_dir) m_w1 = m_w0 + m_pulses / m_period;
                else       m_w1 = m_w0 - m_pulses / m_period;
                if (m_w1 > 16) m_w1 = 16;
                if (m_w1 < 0)  m_w1 = 0;
            end
        end else if (!was_done && st && !ab) begin
            m_dir    = dr;
            m_period = (rt + 1) * 256;
            m_pulses = 0;
            m_w0     = m_w1;
            if (m_w1 == (dr ? 16 : 0)) m_done = 1;
            else                       m_fading = 1;
        end
    endtask

    task automatic tick(input bit rst, st, ab, dr, input int rt,
                        input bit rdy, input int bass);
        int e1, e2;
        bit dk;
        reset         = rst;
        bus.start     = st;
        bus.abort     = ab;
        bus.direction = dr;
        bus.rate      = rt[3:0];
        bus.ready     = rdy;
        bus.freq_bass = bass[7:0];
        @(posedge clock);
        #1;
        model(rst, st, ab, dr, rt, rdy, bass);
`ifdef BASS_DUCK_EN
        dk = (m_duck > 0);
`else
        dk = 0;
`endif
        e1 = dk ? m_w1 / 2 : m_w1;
        e2 = dk ? (16 - m_w1) / 2 : 16 - m_w1;
        chk("weight1", int'(bus.weight1), e1);
        chk("weight2", int'(bus.weight2), e2);
        chk("busy", int'(bus.busy), int'(m_fading));
        chk("done", int'(bus.done), int'(m_done));
        if (bus.done) n_done++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    // n ready pulses with random gaps; start asserted mid-way if asked
    task automatic pulses(input int n, input int bass, input bit poke_start);
        int got;
        bit rdy;
        got = 0;
        while (got < n) begin
            rdy = ($urandom_range(3, 0) != 0);
            tick(0, poke_start && (got == n / 2), 0, 1'($urandom),
                 int'($urandom_range(15, 0)), rdy, bass);
            if (rdy) got++;
        end
    endtask

    initial begin
        int d0;
        n_vec = 0; n_err = 0; n_done = 0;
        m_w1 = 16; m_fading = 0; m_done = 0; m_duck = 0;

        // reset state
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(1, 1, 1, 0, 0, 1, 255);
        chk("rst_w1", int'(bus.weight1), 16);
        chk("rst_busy", int'(bus.busy), 0);

        // full fade toward track 2 at the fastest rate
        d0 = n_done;
        tick(0, 1, 0, 0, 0, 0, 0);
        chk("fade_busy", int'(bus.busy), 1);
        pulses(4096, 0, 1);
        idle(3);
        chk("fade_end_w1", int'(bus.weight1), 0);
        chk("fade_done_cnt", n_done - d0, 1);

        // already at target: immediate done, no step
        d0 = n_done;
        tick(0, 1, 0, 0, 0, 0, 0);
        chk("at_target_done", int'(bus.done), 1);
        idle(2);
        chk("at_target_w2", int'(bus.weight2), 16);
        chk("at_target_cnt", n_done - d0, 1);

        // slow fade toward track 1, stray start mid-fade, then abort
        d0 = n_done;
        tick(0, 1, 0, 1, 3, 0, 0);
        pulses(2500, 0, 1);
        tick(0, 0, 1, 0, 0, 1, 0);
        idle(2);
        chk("abort_w1", int'(bus.weight1), 2);
        chk("abort_w2", int'(bus.weight2), 14);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_no_done", n_done - d0, 0);

        // reset mid-fade at weight1 = 8
        tick(0, 1, 0, 1, 0, 0, 0);
        pulses(1536, 0, 0);
        chk("mid_w1", int'(bus.weight1), 8);
        tick(1, 1, 1, 0, 0, 1, 0);
        chk("midrst_w1", int'(bus.weight1), 16);
        chk("midrst_busy", int'(bus.busy), 0);
        tick(0, 1, 1, 0, 0, 0, 0);
        chk("start_abort_busy", int'(bus.busy), 0);

        // bring w1 to 10, then exercise ducking
        tick(0, 1, 0, 0, 0, 0, 0);
        pulses(1536, 0, 0);
        tick(0, 0, 1, 0, 0, 0, 0);
        chk("pre_duck_w1", int'(bus.weight1), 10);
        tick(0, 0, 0, 0, 0, 1, 200);
`ifdef BASS_DUCK_EN
        chk("duck_w1", int'(bus.weight1), 5);
        chk("duck_w2", int'(bus.weight2), 3);
`else
        chk("noduck_w1", int'(bus.weight1), 10);
        chk("noduck_w2", int'(bus.weight2), 6);
`endif
        pulses(2399, 0, 0);
        idle(2);
        pulses(1, 0, 0);
        chk("duck_end_w1", int'(bus.weight1), 10);
        pulses(300, 191, 0);
        chk("thresh_w2", int'(bus.weight2), 6);

        // random traffic
        for (int i = 0; i < 20000; i++) begin
            tick($urandom_range(4095, 0) == 0,
                 $urandom_range(63, 0) == 0,
                 $urandom_range(511, 0) == 0,
                 1'($urandom),
                 int'($urandom_range(1, 0)),
                 $urandom_range(3, 0) != 0,
                 int'($urandom_range(255, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
